// File: rtl/wb_epbuf_wide_if.sv
// Wishbone-side bus bundle for wb_epbuf_wide.
// wb_err exists only when WB_EPBUF_ERR_EN is defined.
interface wb_epbuf_wide_if #(
  parameter int WB_DW = 32,
  parameter int AW    = 7
);
  logic [AW-1:0]      wb_addr;
  logic [WB_DW-1:0]   wb_wdata;
  logic [WB_DW/8-1:0] wb_wmsk;
  logic               wb_we;
  logic               wb_cyc;
  logic [WB_DW-1:0]   wb_rdata;
  logic               wb_ack;
`ifdef WB_EPBUF_ERR_EN
  logic               wb_err;
`endif

  modport master (
    output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
`ifdef WB_EPBUF_ERR_EN
    input  wb_err,
`endif
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
`ifdef WB_EPBUF_ERR_EN
    output wb_err,
`endif
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/wb_epbuf_wide.sv
// Wide Wishbone word to narrow EP buffer bridge: each WB access becomes R sequential EP beats.
// Optional WB_EPBUF_ERR_EN: out-of-range word addresses (>= DEPTH) answer with wb_err instead.
module wb_epbuf_wide #(
  parameter int WB_DW  = 32,
  parameter int EP_DW  = 16,
  parameter int AW     = 7,
  parameter int DEPTH  = 2**AW,
  localparam int R     = WB_DW / EP_DW,
  localparam int LR    = $clog2(R),
  localparam int EP_MW = EP_DW / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_epbuf_wide_if.slave   wb,
  output logic [AW+LR-1:0] ep_tx_addr_0,
  output logic [EP_DW-1:0] ep_tx_data_0,
  output logic [EP_MW-1:0] ep_tx_wmsk_0,
  output logic             ep_tx_we_0,
  output logic [AW+LR-1:0] ep_rx_addr_0,
  input  logic [EP_DW-1:0] ep_rx_data_1,
  output logic             ep_rx_re_0
);

  if (!((WB_DW == 32 || WB_DW == 64) && (EP_DW == 8 || EP_DW == 16))
      || DEPTH < 1 || DEPTH > 2**AW) begin : g_bad_cfg
    $error("wb_epbuf_wide: unsupported WB_DW/EP_DW/DEPTH combination");
  end

  typedef enum logic [1:0] {IDLE, XFER, FLUSH, ACK} state_t;

  localparam logic [LR-1:0] K_LAST = LR'(R - 1);

  state_t           state_q, state_d;
  logic [LR-1:0]    k_q, k_d;
  logic [WB_DW-1:0] rdata_q;
  logic             cap_en;
  logic [LR-1:0]    cap_slot;

`ifdef WB_EPBUF_ERR_EN
  logic err_q, err_d;
  logic oor;

  assign oor = {1'b0, wb.wb_addr} >= (AW+1)'(DEPTH);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
`ifdef WB_EPBUF_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
`ifdef WB_EPBUF_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
`ifdef WB_EPBUF_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (wb.wb_cyc) begin
`ifdef WB_EPBUF_ERR_EN
          err_d   = oor;
          state_d = oor ? ACK : XFER;
`else
          state_d = XFER;
`endif
        end
      end
      XFER: begin
        if (!wb.wb_cyc) begin
          state_d = IDLE;
          k_d     = '0;
        end else if (k_q == K_LAST) begin
          state_d = wb.wb_we ? ACK : FLUSH;
          k_d     = '0;
        end else begin
          k_d = k_q + LR'(1);
        end
      end
      FLUSH:   state_d = wb.wb_cyc ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so beat k lands on slot k-1; the last one lands in FLUSH.
  always_comb begin
    cap_en   = ((state_q == XFER) && !wb.wb_we && (k_q != '0)) || (state_q == FLUSH);
    cap_slot = (state_q == FLUSH) ? K_LAST : k_q - LR'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (cap_en) begin
      rdata_q[EP_DW*int'(cap_slot) +: EP_DW] <= ep_rx_data_1;
    end
  end

  assign wb.wb_rdata = rdata_q;

  // Output logic
  always_comb begin
    ep_tx_addr_0 = '0;
    ep_tx_data_0 = '0;
    ep_tx_wmsk_0 = '0;
    ep_tx_we_0   = 1'b0;
    ep_rx_addr_0 = '0;
    ep_rx_re_0   = 1'b0;
    wb.wb_ack    = 1'b0;
`ifdef WB_EPBUF_ERR_EN
    wb.wb_err    = 1'b0;
`endif
    if (state_q == XFER) begin
      if (wb.wb_we) begin
        ep_tx_we_0   = 1'b1;
        ep_tx_addr_0 = {wb.wb_addr, k_q};
        ep_tx_data_0 = wb.wb_wdata[EP_DW*int'(k_q) +: EP_DW];
        ep_tx_wmsk_0 = wb.wb_wmsk[EP_MW*int'(k_q) +: EP_MW];
      end else begin
        ep_rx_re_0   = 1'b1;
        ep_rx_addr_0 = {wb.wb_addr, k_q};
      end
    end
    if (state_q == ACK) begin
`ifdef WB_EPBUF_ERR_EN
      wb.wb_ack = !err_q;
      wb.wb_err = err_q;
`else
      wb.wb_ack = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_wb_epbuf_wide.sv
// Scoreboard bench for wb_epbuf_wide: a 32/16 instance and a 64/16 instance against word-level reference memories.
module tb_wb_epbuf_wide;
  localparam int AW = 7;
`ifdef WB_EPBUF_ERR_EN
  localparam int DEPTH_A = 64;
`else
  localparam int DEPTH_A = 128;
`endif

  typedef struct {
    int          cyc;
    bit          wr;
    logic [8:0]  addr;
    logic [15:0] data;
    logic [1:0]  msk;
  } beat_t;

  typedef struct {
    int          cyc;
    bit          err;
    bit          chk_d;
    logic [63:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  wb_epbuf_wide_if #(.WB_DW(32), .AW(AW)) ifa ();
  wb_epbuf_wide_if #(.WB_DW(64), .AW(AW)) ifb ();

  logic [7:0]  a_txa, a_rxa;
  logic [15:0] a_txd, a_rxd;
  logic [1:0]  a_txm;
  logic        a_we, a_re;
  logic [8:0]  b_txa, b_rxa;
  logic [15:0] b_txd, b_rxd;
  logic [1:0]  b_txm;
  logic        b_we, b_re;
  logic        err_a, err_b;

  wb_epbuf_wide #(.WB_DW(32), .EP_DW(16), .AW(AW), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .wb(ifa),
    .ep_tx_addr_0(a_txa), .ep_tx_data_0(a_txd), .ep_tx_wmsk_0(a_txm), .ep_tx_we_0(a_we),
    .ep_rx_addr_0(a_rxa), .ep_rx_data_1(a_rxd), .ep_rx_re_0(a_re)
  );

  wb_epbuf_wide #(.WB_DW(64), .EP_DW(16), .AW(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .wb(ifb),
    .ep_tx_addr_0(b_txa), .ep_tx_data_0(b_txd), .ep_tx_wmsk_0(b_txm), .ep_tx_we_0(b_we),
    .ep_rx_addr_0(b_rxa), .ep_rx_data_1(b_rxd), .ep_rx_re_0(b_re)
  );

`ifdef WB_EPBUF_ERR_EN
  assign err_a = ifa.wb_err;
  assign err_b = ifb.wb_err;
`else
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  // EP buffer RAMs with one-cycle read latency, plus a bench-only load port
  logic [15:0] ep_a [256];
  logic [15:0] ep_b [512];
  logic        ld_en = 1'b0;
  logic        ld_sel;
  logic [8:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en && !ld_sel) ep_a[ld_addr[7:0]] <= ld_data;
    else if (a_we) begin
      if (a_txm[0]) ep_a[a_txa][7:0]  <= a_txd[7:0];
      if (a_txm[1]) ep_a[a_txa][15:8] <= a_txd[15:8];
    end
    if (ld_en && ld_sel) ep_b[ld_addr] <= ld_data;
    else if (b_we) begin
      if (b_txm[0]) ep_b[b_txa][7:0]  <= b_txd[7:0];
      if (b_txm[1]) ep_b[b_txa][15:8] <= b_txd[15:8];
    end
    a_rxd <= ep_a[a_rxa];
    b_rxd <= ep_b[b_rxa];
  end

  // Word-level reference memories and expectation queues
  logic [31:0] ref_a [128];
  logic [63:0] ref_b [128];
  logic [31:0] last_a = '0;
  logic [63:0] last_b = '0;
  bit          last_a_ok = 1'b1;
  bit          last_b_ok = 1'b1;
  beat_t       bq_a[$], bq_b[$];
  resp_t       rq_a[$], rq_b[$];
  beat_t       mb_a, mb_b;
  resp_t       mr_a, mr_b;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_we || a_re) begin
      if (bq_a.size() == 0) chk("a_beat_unexpected", 128'({a_we, a_re}), 128'(0));
      else begin
        mb_a = bq_a.pop_front();
        chk("a_beat", {32'(cnt), a_we, a_re, 9'(a_we ? a_txa : a_rxa), a_we ? a_txd : 16'h0, a_we ? a_txm : 2'b0},
                      {32'(mb_a.cyc), mb_a.wr, !mb_a.wr, mb_a.addr, mb_a.wr ? mb_a.data : 16'h0, mb_a.wr ? mb_a.msk : 2'b0});
      end
    end
    if (ifa.wb_ack || err_a) begin
      if (rq_a.size() == 0) chk("a_ack_unexpected", 128'({ifa.wb_ack, err_a}), 128'(0));
      else begin
        mr_a = rq_a.pop_front();
        chk("a_resp", {32'(cnt), ifa.wb_ack, err_a, mr_a.chk_d ? 64'(ifa.wb_rdata) : 64'h0},
                      {32'(mr_a.cyc), !mr_a.err, mr_a.err, mr_a.chk_d ? mr_a.rdata : 64'h0});
      end
    end
  end

  always @(negedge clk) begin
    if (b_we || b_re) begin
      if (bq_b.size() == 0) chk("b_beat_unexpected", 128'({b_we, b_re}), 128'(0));
      else begin
        mb_b = bq_b.pop_front();
        chk("b_beat", {32'(cnt), b_we, b_re, b_we ? b_txa : b_rxa, b_we ? b_txd : 16'h0, b_we ? b_txm : 2'b0},
                      {32'(mb_b.cyc), mb_b.wr, !mb_b.wr, mb_b.addr, mb_b.wr ? mb_b.data : 16'h0, mb_b.wr ? mb_b.msk : 2'b0});
      end
    end
    if (ifb.wb_ack || err_b) begin
      if (rq_b.size() == 0) chk("b_ack_unexpected", 128'({ifb.wb_ack, err_b}), 128'(0));
      else begin
        mr_b = rq_b.pop_front();
        chk("b_resp", {32'(cnt), ifb.wb_ack, err_b, mr_b.chk_d ? ifb.wb_rdata : 64'h0},
                      {32'(mr_b.cyc), !mr_b.err, mr_b.err, mr_b.chk_d ? mr_b.rdata : 64'h0});
      end
    end
  end

  task automatic load(input bit sel, input int a, input logic [15:0] v);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 9'(a); ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (!sel) ref_a[a / 2][16*(a % 2) +: 16] = v;
    else      ref_b[a / 4][16*(a % 4) +: 16] = v;
  endtask

  task automatic idle(input int n);
    ifa.wb_cyc = 1'b0;
    ifb.wb_cyc = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a rising edge; C0 is the current cycle. Returns in the cycle after the ack with cyc still high.
  task automatic txn_a(input logic [6:0] addr, input bit wr, input logic [31:0] wd, input logic [3:0] wm);
    int c0, ackc;
    bit err;
    beat_t b;
    resp_t r;
    c0 = cnt;
    err = 1'b0;
`ifdef WB_EPBUF_ERR_EN
    err = (int'(addr) >= DEPTH_A);
`endif
    ifa.wb_addr = addr; ifa.wb_we = wr; ifa.wb_wdata = wd; ifa.wb_wmsk = wm; ifa.wb_cyc = 1'b1;
    if (err) ackc = c0 + 1;
    else begin
      for (int k = 0; k < 2; k++) begin
        b.cyc = c0 + 1 + k; b.wr = wr; b.addr = {1'b0, addr, k[0]};
        b.data = wd[16*k +: 16]; b.msk = wm[2*k +: 2];
        bq_a.push_back(b);
      end
      ackc = wr ? c0 + 3 : c0 + 4;
      if (wr) begin
        for (int j = 0; j < 4; j++) if (wm[j]) ref_a[addr][8*j +: 8] = wd[8*j +: 8];
      end else begin
        last_a = ref_a[addr];
        last_a_ok = 1'b1;
      end
    end
    r.cyc = ackc; r.err = err; r.chk_d = last_a_ok; r.rdata = 64'(last_a);
    rq_a.push_back(r);
    repeat (ackc + 1 - c0) @(posedge clk);
    #1;
  endtask

  task automatic txn_b(input logic [6:0] addr, input bit wr, input logic [63:0] wd, input logic [7:0] wm);
    int c0, ackc;
    beat_t b;
    resp_t r;
    c0 = cnt;
    ifb.wb_addr = addr; ifb.wb_we = wr; ifb.wb_wdata = wd; ifb.wb_wmsk = wm; ifb.wb_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.cyc = c0 + 1 + k; b.wr = wr; b.addr = {addr, k[1:0]};
      b.data = wd[16*k +: 16]; b.msk = wm[2*k +: 2];
      bq_b.push_back(b);
    end
    ackc = wr ? c0 + 5 : c0 + 6;
    if (wr) begin
      for (int j = 0; j < 8; j++) if (wm[j]) ref_b[addr][8*j +: 8] = wd[8*j +: 8];
    end else begin
      last_b = ref_b[addr];
      last_b_ok = 1'b1;
    end
    r.cyc = ackc; r.err = 1'b0; r.chk_d = last_b_ok; r.rdata = last_b;
    rq_b.push_back(r);
    repeat (ackc + 1 - c0) @(posedge clk);
    #1;
  endtask

  // Write whose cyc drops in C0+1: exactly one beat (the low half) reaches the EP buffer.
  task automatic abort_a(input logic [6:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    beat_t b;
    ifa.wb_addr = addr; ifa.wb_we = 1'b1; ifa.wb_wdata = wd; ifa.wb_wmsk = wm; ifa.wb_cyc = 1'b1;
    b.cyc = cnt + 1; b.wr = 1'b1; b.addr = {1'b0, addr, 1'b0}; b.data = wd[15:0]; b.msk = wm[1:0];
    bq_a.push_back(b);
    for (int j = 0; j < 2; j++) if (wm[j]) ref_a[addr][8*j +: 8] = wd[8*j +: 8];
    @(posedge clk); #1;
    ifa.wb_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rst_mid_read_a(input logic [6:0] addr);
    beat_t b;
    ifa.wb_addr = addr; ifa.wb_we = 1'b0; ifa.wb_cyc = 1'b1;
    b.cyc = cnt + 1; b.wr = 1'b0; b.addr = {1'b0, addr, 1'b0}; b.data = '0; b.msk = '0;
    bq_a.push_back(b);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ifa.wb_cyc = 1'b0;
    #1;
    chk("rst_mid_a_outputs", {ifa.wb_rdata, a_txa, a_rxa, a_txd, a_txm, a_we, a_re, ifa.wb_ack, err_a}, '0);
    chk("rst_mid_b_rdata", 128'(ifb.wb_rdata), 128'(0));
    #2;
    rst_n = 1'b1;
    last_a = '0; last_a_ok = 1'b1;
    last_b = '0; last_b_ok = 1'b1;
    idle(4);
  endtask

  initial begin
    rst_n = 1'b1;
    ifa.wb_cyc = 1'b0; ifa.wb_we = 1'b0; ifa.wb_addr = '0; ifa.wb_wdata = '0; ifa.wb_wmsk = '0;
    ifb.wb_cyc = 1'b0; ifb.wb_we = 1'b0; ifb.wb_addr = '0; ifb.wb_wdata = '0; ifb.wb_wmsk = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", {ifa.wb_rdata, a_txa, a_rxa, a_txd, a_txm, a_we, a_re, ifa.wb_ack, err_a}, '0);
    chk("reset_b", {ifb.wb_rdata, b_txa, b_rxa, b_txd, b_txm, b_we, b_re, ifb.wb_ack, err_b}, '0);

    for (int i = 0; i < 256; i++) load(1'b0, i, 16'($urandom));
    for (int i = 0; i < 512; i++) load(1'b1, i, 16'($urandom));
    load(1'b0, 'h20, 16'h1111);
    load(1'b0, 'h21, 16'h2222);
    rst_n = 1'b1;
    idle(2);

    // Directed 32/16 cases: write beat split, read assembly, back-to-back, abort
    txn_a(7'h05, 1'b1, 32'hA1B2C3D4, 4'hF);
    idle(2);
    txn_a(7'h10, 1'b0, 32'h0, 4'h0);
    txn_a(7'h05, 1'b0, 32'h0, 4'h0);
    idle(1);
    txn_a(7'h06, 1'b1, 32'h12345678, 4'b0101);
    idle(1);
    abort_a(7'h12, 32'hDEADBEEF, 4'hF);
    txn_a(7'h12, 1'b0, 32'h0, 4'h0);
    idle(1);
`ifdef WB_EPBUF_ERR_EN
    txn_a(7'h40, 1'b0, 32'h0, 4'h0);
    idle(1);
    txn_a(7'h40, 1'b1, 32'hCAFEF00D, 4'hF);
    txn_a(7'h3F, 1'b0, 32'h0, 4'h0);
    idle(1);
`endif

    for (int i = 0; i < 40; i++) begin
      txn_a($urandom_range(0, 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(60, 71)),
            1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    rst_mid_read_a(7'h10);
    txn_a(7'h10, 1'b0, 32'h0, 4'h0);
    idle(2);

    // 64/16 instance: four beats per word
    txn_b(7'h03, 1'b0, 64'h0, 8'h0);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      txn_b(7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);

    chk("a_pending", 128'(rq_a.size() + bq_a.size()), 128'(0));
    chk("b_pending", 128'(rq_b.size() + bq_b.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
